// File: rtl/counting_seq_gen.sv
// Run-length symbol generator: one (n1,n2,n3) descriptor produces n1 x 1, n2 x 2 and n3 x 3 on a valid/ready stream.
// Optional tail symbol (num=1 after the last run) is enabled by defining COUNTING_SEQ_TAIL_EN.
module counting_seq_gen #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_n1,
  input  logic [CNT_W-1:0] cfg_n2,
  input  logic [CNT_W-1:0] cfg_n3,
  output logic [1:0]       num,
  output logic             num_valid,
  input  logic             num_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, RUN1, RUN2, RUN3, TAIL, FIN} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt1_q, cnt2_q, cnt3_q;
  logic [1:0]       num_q;
  logic             num_valid_q, done_q;
  logic             xfer;

  // First state with work left, in run order; falls through to the tail or FIN.
  function automatic state_t pick(input logic h1, input logic h2, input logic h3);
    if (h1) return RUN1;
    if (h2) return RUN2;
    if (h3) return RUN3;
`ifdef COUNTING_SEQ_TAIL_EN
    return TAIL;
`else
    return FIN;
`endif
  endfunction

  function automatic logic [1:0] sym_of(input state_t s);
    case (s)
      RUN1, TAIL: return 2'd1;
      RUN2:       return 2'd2;
      RUN3:       return 2'd3;
      default:    return 2'd0;
    endcase
  endfunction

  assign xfer = num_valid_q && num_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cfg_valid) state_d = pick(cfg_n1 != '0, cfg_n2 != '0, cfg_n3 != '0);
      RUN1: if (xfer && cnt1_q == ONE) state_d = pick(1'b0, cnt2_q != '0, cnt3_q != '0);
      RUN2: if (xfer && cnt2_q == ONE) state_d = pick(1'b0, 1'b0, cnt3_q != '0);
      RUN3: if (xfer && cnt3_q == ONE) state_d = pick(1'b0, 1'b0, 1'b0);
      TAIL: if (xfer) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so run changes happen without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      cnt3_q      <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= sym_of(state_d);
      num_valid_q <= (state_d == RUN1) || (state_d == RUN2) ||
                     (state_d == RUN3) || (state_d == TAIL);
      done_q      <= (state_d == FIN);
      case (state_q)
        IDLE: if (cfg_valid) begin
          cnt1_q <= cfg_n1;
          cnt2_q <= cfg_n2;
          cnt3_q <= cfg_n3;
        end
        RUN1: if (xfer && cnt1_q != '0) cnt1_q <= cnt1_q - ONE;
        RUN2: if (xfer && cnt2_q != '0) cnt2_q <= cnt2_q - ONE;
        RUN3: if (xfer && cnt3_q != '0) cnt3_q <= cnt3_q - ONE;
        default: ;
      endcase
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = ~cfg_ready;
  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_counting_seq_gen.sv
// Scoreboard bench for counting_seq_gen: stimulus queues expected symbols, a negedge monitor checks transfers.
module tb_counting_seq_gen;

  localparam int CNT_W = 4;
`ifdef COUNTING_SEQ_TAIL_EN
  localparam int TAIL_N = 1;
`else
  localparam int TAIL_N = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_n1 = '0, cfg_n2 = '0, cfg_n3 = '0;
  logic [1:0]       num;
  logic             num_valid;
  logic             num_ready = 1'b1;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;
  int xfer_cnt = 0;
  int done_seen = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  counting_seq_gen #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n1(cfg_n1), .cfg_n2(cfg_n2), .cfg_n3(cfg_n3),
    .num(num), .num_valid(num_valid), .num_ready(num_ready),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every transfer pops one expected symbol.
  always @(negedge clk) begin
    if (!reset) begin
      if (num_valid && num_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected symbol: got %0d, expected none", num);
        end else begin
          chk("symbol", int'(num), exp_q.pop_front());
        end
      end
      if (!num_valid && num != 2'd0) chk("num zero when idle", int'(num), 0);
      if (done) done_seen++;
    end
  end

  task automatic send(input int a, input int b, input int c);
    int guard = 0;
    xfer_cnt = 0;
    @(negedge clk);
    while (!cfg_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cfg_ready) begin
      $display("FAIL cfg_ready timeout: got 0, expected 1");
      $fatal(1);
    end
    for (int i = 0; i < a; i++) exp_q.push_back(1);
    for (int i = 0; i < b; i++) exp_q.push_back(2);
    for (int i = 0; i < c; i++) exp_q.push_back(3);
    for (int i = 0; i < TAIL_N; i++) exp_q.push_back(1);
    cfg_n1 = CNT_W'(a);
    cfg_n2 = CNT_W'(b);
    cfg_n3 = CNT_W'(c);
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start = done_seen;
    int k = 0;
    while (done_seen == start && k < budget) begin
      @(negedge clk);
      #1 k++;
    end
    if (done_seen == start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done timeout: got no done, expected done within %0d cycles", budget);
    end
    chk("queue drained", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset cfg_ready", int'(cfg_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset num_valid", int'(num_valid), 0);
    chk("reset num", int'(num), 0);
    chk("reset done", int'(done), 0);
    reset = 1'b0;

    // 1: 2,1,2 full throughput
    send(2, 1, 2);
    chk("t1 first valid", int'(num_valid), 1);
    chk("t1 first num", int'(num), 1);
    chk("t1 busy", int'(busy), 1);
    repeat (5 + TAIL_N) @(posedge clk);
    #1 chk("t1 done timing", int'(done), 1);
    chk("t1 cfg_ready in FIN", int'(cfg_ready), 0);
    wait_done(50);
    @(posedge clk);
    #1 chk("t1 idle after done", int'(cfg_ready), 1);
    chk("t1 done one cycle", int'(done), 0);

    // 2: only run 2
    send(0, 3, 0);
    chk("t2 first num", int'(num), 2);
    wait_done(50);
    chk("t2 transfers", xfer_cnt, 3 + TAIL_N);

    // 3: backpressure mid run 1
    send(2, 1, 2);
    @(posedge clk);
    #1 num_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("t3 stall valid", int'(num_valid), 1);
      chk("t3 stall num", int'(num), 1);
    end
    num_ready = 1'b1;
    wait_done(50);
    chk("t3 transfers", xfer_cnt, 5 + TAIL_N);

    // 4: all zero
    send(0, 0, 0);
`ifndef COUNTING_SEQ_TAIL_EN
    chk("t4 done at accept+1", int'(done), 1);
    chk("t4 no valid", int'(num_valid), 0);
`endif
    wait_done(50);
    @(posedge clk);
    #1 chk("t4 cfg_ready after", int'(cfg_ready), 1);
    chk("t4 transfers", xfer_cnt, TAIL_N);

    // 5: max runs, ignored descriptor while busy
    d0 = done_seen;
    send(15, 15, 15);
    repeat (10) @(posedge clk);
    #1 chk("t5 cfg_ready busy", int'(cfg_ready), 0);
    cfg_n1 = 4'd5; cfg_n2 = 4'd5; cfg_n3 = 4'd5;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    wait_done(200);
    repeat (10) @(posedge clk);
    #1 chk("t5 transfers", xfer_cnt, 45 + TAIL_N);
    chk("t5 done once", done_seen - d0, 1);

    // 6: reset after third transfer
    d0 = done_seen;
    send(3, 3, 3);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 chk("t6 num_valid after reset", int'(num_valid), 0);
    chk("t6 cfg_ready after reset", int'(cfg_ready), 1);
    chk("t6 num after reset", int'(num), 0);
    chk("t6 transfers before reset", xfer_cnt, 3);
    reset = 1'b0;
    exp_q.delete();
    repeat (8) @(posedge clk);
    #1 chk("t6 no done", done_seen - d0, 0);
    chk("t6 idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
